// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the bit-serial ALU.
package alu_pkg;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: gate primitives plus a full adder, selected by opcode.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       res_bit,
    output logic       cout
);

    logic n_a, and_ab, or_ab, x_ab, sum, and_cx, fa_cout;

    not u_not  (n_a,     a_bit);
    and u_and  (and_ab,  a_bit, b_bit);
    or  u_or   (or_ab,   a_bit, b_bit);
    xor u_xab  (x_ab,    a_bit, b_bit);
    xor u_sum  (sum,     x_ab,  cin);
    and u_cx   (and_cx,  cin,   x_ab);
    or  u_cout (fa_cout, and_ab, and_cx);

    always_comb begin
        res_bit = 1'b0;
        case (op)
            OP_NOT:  res_bit = n_a;
            OP_AND:  res_bit = and_ab;
            OP_OR:   res_bit = or_ab;
            default: res_bit = sum;
        endcase
    end

    // Carry only propagates for ADD so the carry flop stays clear otherwise.
    assign cout = (op == OP_ADD) & fa_cout;

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: captures operands, pushes them LSB first through one slice,
// and reassembles the result with a one-cycle done pulse.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh, res_sh, res_nxt;
    logic [1:0]         op_r;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               slice_res, slice_cout;
    logic               last;

    alu_bit_slice u_slice (
        .a_bit   (a_sh[0]),
        .b_bit   (b_sh[0]),
        .cin     (carry),
        .op      (op_r),
        .res_bit (slice_res),
        .cout    (slice_cout)
    );

    assign last    = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign res_nxt = {slice_res, res_sh[WIDTH-1:1]};
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            op_r      <= OP_NOT;
            cnt       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (state == S_IDLE && start) begin
            a_sh   <= a;
            b_sh   <= b;
            op_r   <= op;
            res_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
        end else if (state == S_RUN) begin
            res_sh <= res_nxt;
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= slice_cout;
            cnt    <= cnt + CNT_W'(1);
            // Outputs move only here, so they never show a partial result.
            if (last) begin
                result    <= res_nxt;
                carry_out <= slice_cout;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Self-checking bench for bit_serial_alu against an arithmetic reference model.
module tb_bit_serial_alu;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, start;
    logic [1:0]   op;
    logic [W-1:0] a, b, result;
    logic         busy, done, carry_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out)
    );

    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            OP_NOT:  return {1'b0, ~x};
            OP_AND:  return {1'b0, x & y};
            OP_OR:   return {1'b0, x | y};
            default: return {1'b0, x} + {1'b0, y};
        endcase
    endfunction

    // Issues one operation and observes it until busy drops (bounded).
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit scramble, input bit poke,
                         output logic [W-1:0] r, output logic c,
                         output int lat, output int nbusy, output int ndone);
        r = 'x; c = 1'bx; lat = -1; nbusy = 0; ndone = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        if (scramble) begin a = '0; b = '0; op = OP_NOT; end
        if (poke) begin start = 1'b1; op = OP_OR; a = '0; b = '0; end
        if (busy) nbusy++;
        for (int k = 1; k <= 4 * W; k++) begin
            @(posedge clk); #1;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                r = result; c = carry_out;
                if (lat < 0) lat = k;
            end
            if (poke) start = done;
            if (!busy) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = OP_NOT; a = '0; b = '0;
        #12;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (result !== '0) begin n_err++; $display("FAIL reset_result: got %h expected 00", result); end
        n_vec++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
        start = 1'b1; op = OP_ADD; a = 8'h11; b = 8'h22;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_start_ignored: busy got %b expected 0", busy); end
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [1:0]   t_op [7] = '{OP_ADD, OP_ADD, OP_NOT, OP_AND, OP_OR, OP_AND, OP_OR};
        logic [W-1:0] t_a  [7] = '{8'h5A, 8'hFF, 8'hA5, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
        logic [W-1:0] t_b  [7] = '{8'h3C, 8'h01, 8'h77, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
        logic [W-1:0] t_r  [7] = '{8'h96, 8'h00, 8'h5A, 8'h30, 8'hFC, 8'h30, 8'hFC};
        logic         t_c  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] r; logic c; int lat, nb, nd;
        for (int i = 0; i < 7; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], i >= 5, 1'b0, r, c, lat, nb, nd);
            n_vec++; if (r !== t_r[i]) begin n_err++; $display("FAIL dir%0d_result: got %h expected %h", i, r, t_r[i]); end
            n_vec++; if (c !== t_c[i]) begin n_err++; $display("FAIL dir%0d_carry: got %b expected %b", i, c, t_c[i]); end
            n_vec++; if (lat !== W) begin n_err++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, W); end
            n_vec++; if (nb !== W + 1) begin n_err++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, nb, W + 1); end
            n_vec++; if (nd !== 1) begin n_err++; $display("FAIL dir%0d_done_pulses: got %0d expected 1", i, nd); end
        end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] r; logic c; int lat, nb, nd;
        do_op(OP_AND, 8'hFF, 8'h0F, 1'b0, 1'b1, r, c, lat, nb, nd);
        n_vec++; if (r !== 8'h0F) begin n_err++; $display("FAIL busy_ign_result: got %h expected 0f", r); end
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL busy_ign_pulses: got %0d expected 1", nd); end
        n_vec++; if (lat !== W) begin n_err++; $display("FAIL busy_ign_latency: got %0d expected %0d", lat, W); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL busy_ign_not_queued: busy %b done %b expected 0 0", busy, done); end
        end
        do_op(OP_OR, 8'h12, 8'h21, 1'b0, 1'b0, r, c, lat, nb, nd);
        n_vec++; if (r !== 8'h33) begin n_err++; $display("FAIL busy_ign_next: got %h expected 33", r); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] r; logic c; int lat, nb, nd;
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 8'h80; b = 8'h80;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL arst_pre_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL arst_done: got %b expected 0", done); end
        n_vec++; if (result !== '0) begin n_err++; $display("FAIL arst_result: got %h expected 00", result); end
        n_vec++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL arst_carry: got %b expected 0", carry_out); end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk); #1;
            n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL arst_abandoned: busy %b done %b expected 0 0", busy, done); end
        end
        do_op(OP_ADD, 8'h01, 8'h02, 1'b0, 1'b0, r, c, lat, nb, nd);
        n_vec++; if (r !== 8'h03) begin n_err++; $display("FAIL arst_after: got %h expected 03", r); end
        n_vec++; if (c !== 1'b0) begin n_err++; $display("FAIL arst_after_carry: got %b expected 0", c); end
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses.push_back(k);
                n_vec++; if (result !== 8'h02) begin n_err++; $display("FAIL b2b_result: got %h expected 02", result); end
            end
        end
        start = 1'b0;
        n_vec++; if (pulses.size() !== 3) begin n_err++; $display("FAIL b2b_count: got %0d expected 3", pulses.size()); end
        if (pulses.size() > 0) begin
            n_vec++; if (pulses[0] !== W) begin n_err++; $display("FAIL b2b_first: got %0d expected %0d", pulses[0], W); end
        end
        for (int i = 1; i < pulses.size(); i++) begin
            n_vec++; if (pulses[i] - pulses[i-1] !== W + 2) begin n_err++; $display("FAIL b2b_spacing: got %0d expected %0d", pulses[i] - pulses[i-1], W + 2); end
        end
        repeat (2 * W + 4) @(posedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] r, x, y; logic c; logic [1:0] o; logic [W:0] exp; int lat, nb, nd;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3)); x = W'($urandom); y = W'($urandom);
            exp = model(o, x, y);
            do_op(o, x, y, bit'($urandom_range(0, 1)), 1'b0, r, c, lat, nb, nd);
            n_vec++; if ({c, r} !== exp) begin n_err++; $display("FAIL rand%0d op%0d a=%h b=%h: got %b_%h expected %b_%h", i, o, x, y, c, r, exp[W], exp[W-1:0]); end
            n_vec++; if (lat !== W || nd !== 1) begin n_err++; $display("FAIL rand%0d_timing: latency %0d pulses %0d expected %0d 1", i, lat, nd, W); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
